// File: rtl/button_led_host_peer.sv
// Host-side peer for the button/LED UART protocol: sends 24-bit button frames and receives 8-bit LED bytes.
// Optional macro BUTTON_HOST_SEND_ON_CHANGE_EN: also request a frame whenever buttons_in changes.
module button_led_host_peer #(
  parameter int unsigned CLKS_PER_BIT  = 868,
  parameter logic [31:0] CLKS_PER_SYNC = 32'd1666666
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] buttons_in,
  input  logic        send,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [7:0]  leds_out,
  output logic        leds_valid,
  output logic        tx_busy,
  output logic        frame_error
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [1:0]       tx_byte_q, tx_byte_d;
  logic [23:0]      tx_shift_q, tx_shift_d;
  logic             uart_tx_d, tx_busy_d, pending_q, pending_d;
  logic [31:0]      sync_cnt_q, sync_cnt_d;
  logic             sync_hit_c, change_c, req_c, start_c;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_s1_q, rx_s2_q, rx_s3_q, rx_fall_c;
  logic [7:0]       leds_d;
  logic             leds_valid_d, frame_error_d;

`ifdef BUTTON_HOST_SEND_ON_CHANGE_EN
  logic [23:0] btn_prev_q;
  // Tracks buttons_in unconditionally so a reset never manufactures a change event
  always_ff @(posedge CLK) btn_prev_q <= buttons_in;
  assign change_c = (buttons_in != btn_prev_q);
`else
  assign change_c = 1'b0;
`endif

  assign sync_hit_c = (CLKS_PER_SYNC != 32'd0) && (sync_cnt_q == CLKS_PER_SYNC - 32'd1);
  assign req_c      = send | sync_hit_c | change_c;
  assign sync_cnt_d = (CLKS_PER_SYNC == 32'd0 || start_c || sync_hit_c) ? 32'd0
                                                                        : sync_cnt_q + 32'd1;

  // TX frame sequencer; the byte in flight always sits in tx_shift_q[7:0]
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_byte_d  = tx_byte_q;
    tx_shift_d = tx_shift_q;
    uart_tx_d  = uart_tx;
    tx_busy_d  = tx_busy;
    pending_d  = pending_q;
    start_c    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (req_c || pending_q) begin
          start_c    = 1'b1;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_byte_d  = 2'd0;
          tx_shift_d = buttons_in;
          uart_tx_d  = 1'b0;
          tx_busy_d  = 1'b1;
          pending_d  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
          uart_tx_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            uart_tx_d  = 1'b1;
          end else begin
            tx_bit_d  = tx_bit_q + 3'd1;
            uart_tx_d = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_byte_q == 2'd2) begin
            tx_state_d = TX_DONE;
            tx_busy_d  = 1'b0;
            uart_tx_d  = 1'b1;
          end else begin
            tx_state_d = TX_START;
            tx_byte_d  = tx_byte_q + 2'd1;
            tx_bit_d   = 3'd0;
            uart_tx_d  = 1'b0;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      TX_DONE: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    if (req_c && tx_state_q != TX_IDLE) pending_d = 1'b1;
  end

  assign rx_fall_c = rx_s3_q & ~rx_s2_q;

  // RX byte receiver, sampling the synchronized line at bit centres
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    leds_d        = leds_out;
    leds_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall_c) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            leds_d       = rx_shift_q;
            leds_valid_d = 1'b1;
            rx_state_d   = RX_IDLE;
          end else begin
            frame_error_d = 1'b1;
            rx_state_d    = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: if (rx_s2_q) rx_state_d = RX_IDLE;
      default:      rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_byte_q   <= 2'd0;
      tx_shift_q  <= 24'd0;
      uart_tx     <= 1'b1;
      tx_busy     <= 1'b0;
      pending_q   <= 1'b0;
      sync_cnt_q  <= 32'd0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      leds_out    <= 8'd0;
      leds_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      tx_shift_q  <= tx_shift_d;
      uart_tx     <= uart_tx_d;
      tx_busy     <= tx_busy_d;
      pending_q   <= pending_d;
      sync_cnt_q  <= sync_cnt_d;
      rx_s1_q     <= uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_s3_q     <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      leds_out    <= leds_d;
      leds_valid  <= leds_valid_d;
      frame_error <= frame_error_d;
    end
  end

endmodule

// File: tb/tb_button_led_host_peer.sv
// Randomized self-checking bench for button_led_host_peer: line-level frame model, RX driver, sync timing.
module tb_button_led_host_peer;

  localparam int CPB = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [23:0] buttons_in = 24'hA5C33C;
  logic        send = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx, leds_valid, tx_busy, frame_error;
  logic [7:0]  leds_out;

  logic [23:0] s_buttons = 24'h123456;
  logic        s_send = 1'b0;
  logic        s_rx = 1'b1;
  logic        s_tx, s_valid, s_busy, s_ferr;
  logic [7:0]  s_leds;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int last_valid_cyc = 0;
  int d_starts = 0;
  logic d_busy_prev = 1'b0;
  logic s_busy_prev = 1'b0;
  int s_starts[$];
  logic [7:0] exp_leds = 8'h00;

  button_led_host_peer #(.CLKS_PER_BIT(CPB), .CLKS_PER_SYNC(32'd0)) u_dut (
    .CLK(CLK), .RST(RST), .buttons_in(buttons_in), .send(send), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .leds_out(leds_out), .leds_valid(leds_valid), .tx_busy(tx_busy),
    .frame_error(frame_error));

  button_led_host_peer #(.CLKS_PER_BIT(CPB), .CLKS_PER_SYNC(32'd200)) u_sync (
    .CLK(CLK), .RST(RST), .buttons_in(s_buttons), .send(s_send), .uart_rx(s_rx),
    .uart_tx(s_tx), .leds_out(s_leds), .leds_valid(s_valid), .tx_busy(s_busy),
    .frame_error(s_ferr));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Output monitors
  always @(negedge CLK) begin
    if (leds_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
    end
    if (frame_error) ferr_cnt++;
    if (leds_valid || frame_error) check_eq("valid_ferr_excl", 32'(leds_valid & frame_error), 0);
    if (tx_busy && !d_busy_prev) d_starts++;
    d_busy_prev = tx_busy;
    if (s_busy && !s_busy_prev) s_starts.push_back(cyc);
    s_busy_prev = s_busy;
  end

  // Expected serial line value c cycles after a frame starts, straight from the frame format
  function automatic logic exp_line(input logic [23:0] b, input int c);
    int bi, pos;
    logic [7:0] by;
    bi  = c / CPB;
    pos = bi % 10;
    by  = b[(bi / 10) * 8 +: 8];
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return by[pos - 1];
  endfunction

  task automatic capture_frame(output logic [119:0] line, output int busy, output bit seen);
    line = '1;
    busy = 0;
    seen = 1'b0;
    for (int w = 0; w < 300 && !tx_busy; w++) @(negedge CLK);
    if (!tx_busy) return;
    seen = 1'b1;
    for (int c = 0; c < 124; c++) begin
      if (c < 120) line[c] = uart_tx;
      if (tx_busy) busy++;
      @(negedge CLK);
    end
  endtask

  task automatic check_frame(input logic [119:0] line, input int busy, input bit seen,
                             input logic [23:0] b);
    int werr;
    logic [23:0] got;
    werr = 0;
    for (int c = 0; c < 120; c++) if (line[c] !== exp_line(b, c)) werr++;
    for (int i = 0; i < 24; i++) got[i] = line[((i / 8) * 10 + 1 + i % 8) * CPB + CPB / 2];
    check_eq("tx_seen", 32'(seen), 1);
    check_eq("tx_wave_errs", 32'(werr), 0);
    check_eq("tx_data", 32'(got), 32'(b));
    check_eq("tx_busy_cycles", 32'(busy), 120);
    check_eq("tx_idle_after", 32'(uart_tx), 1);
  endtask

  task automatic send_and_check(input logic [23:0] b);
    logic [119:0] line;
    int busy;
    bit seen;
    @(negedge CLK);
    buttons_in = b;
    send = 1'b1;
    @(negedge CLK);
    send = 1'b0;
    capture_frame(line, busy, seen);
    check_frame(line, busy, seen, b);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge CLK);
    end
    uart_rx = 1'b1;
  endtask

  task automatic rx_byte_check(input logic [7:0] d);
    int v0, f0, t0, lat;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    t0 = cyc;
    drive_rx(d, 1'b1);
    repeat (6) @(negedge CLK);
    exp_leds = d;
    lat = last_valid_cyc - t0;
    check_eq("rx_valid_pulses", 32'(valid_cnt - v0), 1);
    check_eq("rx_leds", 32'(leds_out), 32'(exp_leds));
    check_eq("rx_no_ferr", 32'(ferr_cnt - f0), 0);
    check_eq("rx_latency_ok", 32'(lat >= 36 && lat <= 44), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_uart_tx"}, 32'(uart_tx), 1);
    check_eq({tag, "_tx_busy"}, 32'(tx_busy), 0);
    check_eq({tag, "_leds_out"}, 32'(leds_out), 0);
    check_eq({tag, "_leds_valid"}, 32'(leds_valid), 0);
    check_eq({tag, "_frame_error"}, 32'(frame_error), 0);
  endtask

  initial begin
    logic [119:0] line;
    int busy, v0, f0, d0;
    bit seen;
    logic [23:0] b;

    repeat (3) @(negedge CLK);
    check_reset_outputs("rst");
    RST = 1'b0;

    send_and_check(24'hA5C33C);
    rx_byte_check(8'h5A);

    // Bad stop bit leaves the LED byte alone; the receiver then recovers
    rx_byte_check(8'hC4);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive_rx(8'hFF, 1'b0);
    repeat (8) @(negedge CLK);
    check_eq("ferr_pulses", 32'(ferr_cnt - f0), 1);
    check_eq("ferr_no_valid", 32'(valid_cnt - v0), 0);
    check_eq("ferr_leds_kept", 32'(leds_out), 32'(exp_leds));
    rx_byte_check(8'h01);

    // Random traffic with TX and RX overlapping
    for (int k = 0; k < 4; k++) begin
      b = 24'($urandom);
      fork
        send_and_check(b);
        begin
          repeat ($urandom_range(0, 30)) @(negedge CLK);
          rx_byte_check(8'($urandom));
        end
      join
    end

    // Reset in the middle of TX byte 1 and of an RX byte
    fork
      begin
        repeat (35) @(negedge CLK);
        drive_rx(8'h96, 1'b1);
      end
      begin
        @(negedge CLK);
        buttons_in = 24'($urandom);
        send = 1'b1;
        @(negedge CLK);
        send = 1'b0;
        repeat (55) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midrst");
        RST = 1'b0;
      end
    join
    repeat (40) @(negedge CLK);
    send_and_check(24'($urandom));
    rx_byte_check(8'($urandom));

    // Toggle buttons bit 17 with no send
    b = buttons_in ^ 24'h020000;
    @(negedge CLK);
    buttons_in = b;
    capture_frame(line, busy, seen);
`ifdef BUTTON_HOST_SEND_ON_CHANGE_EN
    check_frame(line, busy, seen, b);
    check_eq("chg_byte2_bit1", 32'(line[(20 + 1 + 1) * CPB + CPB / 2]), 32'(b[17]));
`else
    check_eq("chg_no_frame", 32'(seen), 0);
`endif

    // Periodic sync frames and pending coalescing on the second instance
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    s_starts.delete();
    d0 = d_starts;
    for (int w = 0; w < 1000 && s_starts.size() < 3; w++) @(negedge CLK);
    check_eq("sync_three_starts", 32'(s_starts.size() >= 3), 1);
    if (s_starts.size() >= 3) begin
      check_eq("sync_period_a", 32'(s_starts[1] - s_starts[0]), 200);
      check_eq("sync_period_b", 32'(s_starts[2] - s_starts[1]), 200);
    end
    repeat (30) @(negedge CLK);
    s_send = 1'b1;
    @(negedge CLK);
    s_send = 1'b0;
    repeat (10) @(negedge CLK);
    s_send = 1'b1;
    @(negedge CLK);
    s_send = 1'b0;
    for (int w = 0; w < 1000 && s_starts.size() < 5; w++) @(negedge CLK);
    check_eq("pend_five_starts", 32'(s_starts.size() >= 5), 1);
    if (s_starts.size() >= 5) begin
      check_eq("pend_gap", 32'(s_starts[3] - s_starts[2]), 122);
      check_eq("pend_sync_after", 32'(s_starts[4] - s_starts[3]), 200);
    end
    repeat (150) @(negedge CLK);
    check_eq("pend_coalesced", 32'(s_starts.size()), 5);
    check_eq("sync0_no_frames", 32'(d_starts - d0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
